fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of the 16-bit × 8-deep synchronous FIFO among NUM_REQ producer clients. It grants one requester at a time for a bounded burst, drives the FIFO's wr_en/data_in, and stalls against FIFO full. It sits directly in front of the FIFO's write side; the read side is untouched.

## Interface
- NUM_REQ, 4: number of write requesters (2..8)
- DATA_WIDTH, 16: must equal the FIFO width
- MAX_BURST, 4: maximum beats per grant (1..8)
- clk  input  1  single clock; all logic is rising-edge
- rst_n  input  1  asynchronous, active-low reset
- req  input  NUM_REQ  per-client write request; held until granted beat completes
- req_data  input  NUM_REQ*DATA_WIDTH  client i data in slice [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  input  NUM_REQ  marks the client's final beat of a burst
- gnt  output  NUM_REQ  one-hot; beat from client i transferred this cycle
- fifo_wr_en  output  1  to FIFO wr_en
- fifo_data_in  output  DATA_WIDTH  to FIFO data_in
- fifo_full  input  1  from FIFO full
- fifo_wr_ack  input  1  from FIFO wr_ack (only consumed by the stats feature)
- busy  output  1  high while a burst owns the port

## Operation
- States: IDLE, ARB, BURST.
- IDLE: go to ARB when any req bit is high.
- ARB (1 cycle): scan req starting at rr_ptr, wrapping modulo NUM_REQ; register first hit as owner; beat_cnt ← 0; go to BURST. If req has dropped to all-zero, return to IDLE.
- BURST: transfer = req[owner] && !fifo_full. On transfer: fifo_wr_en=1, gnt[owner]=1, fifo_data_in = owner's slice, beat_cnt increments.
- BURST exit to IDLE (rr_ptr ← owner+1 mod NUM_REQ) when any of: transfer with req_last[owner]=1; transfer making beat_cnt == MAX_BURST; req[owner]=0.
- fifo_full in BURST: no transfer, gnt=0, state and beat_cnt hold; resumes when full clears.
- Non-owner requests are ignored until the current burst ends; no preemption.
- fifo_data_in is driven with the owner's slice in BURST and 0 otherwise.
- beat_cnt is $clog2(MAX_BURST+1) bits wide; rr_ptr and owner are $clog2(NUM_REQ) bits, with explicit wrap when NUM_REQ is not a power of 2.

## Timing
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, owner=0, beat_cnt=0; gnt=0, fifo_wr_en=0, fifo_data_in=0, busy=0.
- gnt, fifo_wr_en and fifo_data_in are combinational from registered state, req and fifo_full. No cycle stalls on full.
- Latency: req rising in cycle N (state IDLE) → ARB in N+1 → first gnt in N+2.
- Back-to-back bursts: IDLE→ARB→BURST adds a 2-cycle gap between owners.
- Peak throughput: MAX_BURST beats per MAX_BURST+2 cycles.
- busy=1 exactly in BURST.
- A reset mid-burst aborts the burst immediately; the partially written burst stays in the FIFO; rr_ptr restarts at 0.

## Configuration
- FIFO_ARB_STATS_EN defined: adds output stat_cnt (NUM_REQ*16 bits). Counter i increments on each cycle with gnt[i] && fifo_wr_ack the following cycle (i.e., an accepted write), saturates at 16'hFFFF, and resets to 0.
- Not defined: no stat_cnt port, no counters; fifo_wr_ack is unused.

## Structure
- Package fifo_arb_pkg: FIFO_WIDTH=16, FIFO_DEPTH=8 constants, and the state enum typedef (IDLE, ARB, BURST).
- Sub-module fifo_arb_rr_pick: combinational round-robin picker (req, rr_ptr → valid, index). It is instantiated once in ARB logic.

## Test plan
- Single client: req=4'b0010, 3 beats, last on beat 3 → gnt=4'b0010 on cycles N+2..N+4; FIFO holds the 3 words in order; rr_ptr=2.
- Fairness: req=4'b1111 held with req_last never set, MAX_BURST=4 → owners 0,1,2,3,0 in order, 4 beats each, with a 2-cycle gap between owners.
- Full stall: owner 1 mid-burst, fifo_full=1 for 3 cycles → gnt=0 and fifo_wr_en=0 for those cycles; beat_cnt is held; resumes with no lost or duplicated word.
- Wrap and overflow: 9 beats into an empty FIFO across 3 bursts → the 9th beat is held off by full; the FIFO overflow output never asserts.
- Requester drop: owner 2 drops req after 1 beat → IDLE next cycle; next grant goes to client 3 if requesting.
- Reset mid-burst: rst_n low during BURST beat 2 → all outputs 0 immediately; after release, first grant goes to the lowest active index; with FIFO_ARB_STATS_EN, stat_cnt is cleared.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared constants and state encoding for the FIFO write-port arbiter.
// The FIFO_ARB_STATS_EN macro (see fifo_wr_arbiter) needs nothing from this package.
package fifo_arb_pkg;

   localparam int FIFO_WIDTH = 16;
   localparam int FIFO_DEPTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARB   = 2'd1,
      BURST = 2'd2
   } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Client request bus plus FIFO write-side signals of the write-port arbiter.
// slave: arbiter side; master: clients and FIFO side.
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 16
);
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ-1:0]            gnt;
   logic                          fifo_wr_en;
   logic [DATA_WIDTH-1:0]         fifo_data_in;
   logic                          fifo_full;
   logic                          fifo_wr_ack;
   logic                          busy;

   modport slave (
      input  req, req_data, req_last, fifo_full, fifo_wr_ack,
      output gnt, fifo_wr_en, fifo_data_in, busy
   );

   modport master (
      output req, req_data, req_last, fifo_full, fifo_wr_ack,
      input  gnt, fifo_wr_en, fifo_data_in, busy
   );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping
// modulo NUM_REQ (NUM_REQ need not be a power of two).
module fifo_arb_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic               valid,
   output logic [PTR_W-1:0]   index
);

   logic [PTR_W:0]   sum_s;
   logic [PTR_W-1:0] idx_s;

   // Scan from the farthest candidate back so the nearest hit wins.
   always_comb begin
      valid = |req;
      index = '0;
      sum_s = '0;
      idx_s = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         sum_s = {1'b0, rr_ptr} + (PTR_W+1)'(k);
         idx_s = (sum_s >= (PTR_W+1)'(NUM_REQ)) ? PTR_W'(sum_s - (PTR_W+1)'(NUM_REQ))
                                                : sum_s[PTR_W-1:0];
         index = req[idx_s] ? idx_s : index;
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ bursting clients.
// Optional: define FIFO_ARB_STATS_EN to add per-client accepted-write counters (stat_cnt).
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = FIFO_WIDTH,
   parameter int MAX_BURST  = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   fifo_wr_arbiter_if.slave       bus
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]  stat_cnt
`endif
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   arb_state_e             state_r, state_nxt_s;
   logic [PTR_W-1:0]       rr_ptr_r, rr_ptr_nxt_s;
   logic [PTR_W-1:0]       owner_r, owner_nxt_s, owner_inc_s;
   logic [CNT_W-1:0]       beat_cnt_r, beat_cnt_nxt_s, beat_inc_s;
   logic                   pick_valid_s;
   logic [PTR_W-1:0]       pick_idx_s;
   logic [NUM_REQ-1:0]     gnt_s;
   logic                   wr_en_s;
   logic [DATA_WIDTH-1:0]  data_s;

   fifo_arb_rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
      .req    (bus.req),
      .rr_ptr (rr_ptr_r),
      .valid  (pick_valid_s),
      .index  (pick_idx_s)
   );

   // Next-state, grant and FIFO write-port decode.
   always_comb begin
      state_nxt_s    = state_r;
      rr_ptr_nxt_s   = rr_ptr_r;
      owner_nxt_s    = owner_r;
      beat_cnt_nxt_s = beat_cnt_r;
      gnt_s          = '0;
      wr_en_s        = 1'b0;
      data_s         = '0;
      owner_inc_s    = (owner_r == PTR_W'(NUM_REQ - 1)) ? '0 : owner_r + PTR_W'(1);
      beat_inc_s     = beat_cnt_r + CNT_W'(1);
      case (state_r)
         IDLE: begin
            if (|bus.req) state_nxt_s = ARB;
            else          state_nxt_s = IDLE;
         end
         ARB: begin
            if (pick_valid_s) begin
               owner_nxt_s    = pick_idx_s;
               beat_cnt_nxt_s = '0;
               state_nxt_s    = BURST;
            end else begin
               state_nxt_s    = IDLE;
            end
         end
         BURST: begin
            data_s = bus.req_data[owner_r*DATA_WIDTH +: DATA_WIDTH];
            if (!bus.req[owner_r]) begin
               state_nxt_s  = IDLE;
               rr_ptr_nxt_s = owner_inc_s;
            end else if (!bus.fifo_full) begin
               gnt_s[owner_r] = 1'b1;
               wr_en_s        = 1'b1;
               beat_cnt_nxt_s = beat_inc_s;
               // Burst ends on the client's last beat or when its budget is spent.
               if (bus.req_last[owner_r] || (beat_inc_s == CNT_W'(MAX_BURST))) begin
                  state_nxt_s  = IDLE;
                  rr_ptr_nxt_s = owner_inc_s;
               end else begin
                  state_nxt_s  = BURST;
               end
            end else begin
               state_nxt_s = BURST;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Arbitration state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         rr_ptr_r   <= '0;
         owner_r    <= '0;
         beat_cnt_r <= '0;
      end else begin
         state_r    <= state_nxt_s;
         rr_ptr_r   <= rr_ptr_nxt_s;
         owner_r    <= owner_nxt_s;
         beat_cnt_r <= beat_cnt_nxt_s;
      end
   end

   assign bus.gnt          = gnt_s;
   assign bus.fifo_wr_en   = wr_en_s;
   assign bus.fifo_data_in = data_s;
   assign bus.busy         = (state_r == BURST);

`ifdef FIFO_ARB_STATS_EN
   logic [NUM_REQ-1:0] gnt_d_r;
   logic [15:0]        stat_r [NUM_REQ];

   // wr_ack arrives one cycle after the write, so it pairs with the delayed grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_d_r <= '0;
         for (int i = 0; i < NUM_REQ; i++) stat_r[i] <= 16'h0000;
      end else begin
         gnt_d_r <= gnt_s;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_d_r[i] && bus.fifo_wr_ack && (stat_r[i] != 16'hFFFF))
               stat_r[i] <= stat_r[i] + 16'h0001;
         end
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
      assign stat_cnt[g*16 +: 16] = stat_r[g];
   end
`else
   logic unused_ack_s;
   assign unused_ack_s = bus.fifo_wr_ack;
`endif

endmodule
